// File: rtl/simon_datapath_gen.sv
// Simon datapath: sequence memory, playback/repeat index, guess and legality checks.
// Optional high-score tracking is enabled by defining SIMON_HISCORE_EN.
module simon_datapath_gen #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 64,
  localparam int unsigned ADDR_W = $clog2(DEPTH),
  localparam int unsigned SEQ_W = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        level,
  input  logic [WIDTH-1:0]  pattern,
  input  logic              last_inc,
  input  logic              i_inc,
  input  logic              i_clr,
  input  logic              mem_ld,
  input  logic              s_led_eq_pat,
`ifdef SIMON_HISCORE_EN
  input  logic              hi_clr,
  output logic [ADDR_W:0]   hi_score,
  output logic              hi_new,
`endif
  output logic              i_lt_last,
  output logic              arr_full,
  output logic              correct_pat,
  output logic              legal,
  output logic [WIDTH-1:0]  pattern_leds,
  output logic [ADDR_W:0]   seq_len
);

  localparam logic [ADDR_W-1:0] LAST_MAX = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] i_q;
  logic [ADDR_W-1:0] last_q;
  logic [1:0]        mode_q;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  mem_rd;
  logic [WIDTH-1:0]  drop_low;
  logic [WIDTH-1:0]  drop_two;
  logic              pat_nonzero;

  // Index, sequence end and latched difficulty; reset overrides every strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_q    <= '0;
      last_q <= '0;
      mode_q <= level;
    end else begin
      if (last_inc && (last_q != LAST_MAX)) begin
        last_q <= last_q + ADDR_W'(1);
      end
      if (i_clr) begin
        i_q <= '0;
      end else if (i_inc) begin
        i_q <= (i_q == last_q) ? '0 : i_q + ADDR_W'(1);
      end
    end
  end

  // Pattern store, written at the pre-edge end index; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && mem_ld) begin
      mem[last_q] <= pattern;
    end
  end

  assign mem_rd       = mem[i_q];
  assign pattern_leds = s_led_eq_pat ? pattern : mem_rd;
  assign correct_pat  = (pattern == mem_rd);
  assign i_lt_last    = (i_q < last_q);
  assign arr_full     = (last_q == LAST_MAX);
  assign seq_len      = SEQ_W'(last_q) + SEQ_W'(1);

  // Clearing the lowest set bit once/twice yields the one- and two-bit tests.
  always_comb begin
    drop_low    = pattern & (pattern - WIDTH'(1));
    drop_two    = drop_low & (drop_low - WIDTH'(1));
    pat_nonzero = (pattern != '0);
    legal       = 1'b0;
    case (mode_q)
      2'b00:   legal = pat_nonzero && (drop_low == '0);
      2'b01:   legal = pat_nonzero && (drop_two == '0);
      default: legal = pat_nonzero;
    endcase
  end

`ifdef SIMON_HISCORE_EN
  logic [ADDR_W:0] hi_score_q = '0;
  logic            hi_new_q = 1'b0;
  logic [ADDR_W:0] seq_next;
  logic            last_step;

  assign seq_next  = seq_len + SEQ_W'(1);
  assign last_step = last_inc && !arr_full;

  // Best round length persists across game resets; only hi_clr erases it.
  always_ff @(posedge clk) begin
    if (hi_clr) begin
      hi_score_q <= '0;
      hi_new_q   <= 1'b0;
    end else if (rst) begin
      hi_new_q <= 1'b0;
    end else if (last_step && (seq_next > hi_score_q)) begin
      hi_score_q <= seq_next;
      hi_new_q   <= 1'b1;
    end
  end

  assign hi_score = hi_score_q;
  assign hi_new   = hi_new_q;
`endif

endmodule

// File: tb/tb_simon_datapath_gen.sv
// Scoreboard bench for simon_datapath_gen: stimulus queues expected values,
// a negedge monitor pops and compares them against the combinational outputs.
module tb_simon_datapath_gen;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  localparam int S_LEGAL = 0;
  localparam int S_SEQ   = 1;
  localparam int S_ILT   = 2;
  localparam int S_FULL  = 3;
  localparam int S_CORR  = 4;
  localparam int S_LEDS  = 5;
  localparam int S_HIS   = 6;
  localparam int S_HIN   = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        level;
  logic [WIDTH-1:0]  pattern;
  logic              last_inc, i_inc, i_clr, mem_ld, s_led_eq_pat;
  logic              i_lt_last, arr_full, correct_pat, legal;
  logic [WIDTH-1:0]  pattern_leds;
  logic [ADDR_W:0]   seq_len;
`ifdef SIMON_HISCORE_EN
  logic              hi_clr;
  logic [ADDR_W:0]   hi_score;
  logic              hi_new;
`endif

  simon_datapath_gen #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .level        (level),
    .pattern      (pattern),
    .last_inc     (last_inc),
    .i_inc        (i_inc),
    .i_clr        (i_clr),
    .mem_ld       (mem_ld),
    .s_led_eq_pat (s_led_eq_pat),
`ifdef SIMON_HISCORE_EN
    .hi_clr       (hi_clr),
    .hi_score     (hi_score),
    .hi_new       (hi_new),
`endif
    .i_lt_last    (i_lt_last),
    .arr_full     (arr_full),
    .correct_pat  (correct_pat),
    .legal        (legal),
    .pattern_leds (pattern_leds),
    .seq_len      (seq_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sel;
    int unsigned exp;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  int unsigned act;
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic int unsigned sample(int sel);
    case (sel)
      S_LEGAL: return 32'(legal);
      S_SEQ:   return 32'(seq_len);
      S_ILT:   return 32'(i_lt_last);
      S_FULL:  return 32'(arr_full);
      S_CORR:  return 32'(correct_pat);
      S_LEDS:  return 32'(pattern_leds);
`ifdef SIMON_HISCORE_EN
      S_HIS:   return 32'(hi_score);
      S_HIN:   return 32'(hi_new);
`endif
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Monitor: outputs are combinational, so compare mid-cycle at the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      act = sample(cur.sel);
      n_checks++;
      if (act !== cur.exp) begin
        n_fail++;
        $display("FAIL %s: got %0h, expected %0h", cur.name, act, cur.exp);
      end
    end
  end

  task automatic chk(input string name, input int sel, input int unsigned exp);
    sb.push_back('{name, sel, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    last_inc = 1'b0; i_inc = 1'b0; i_clr = 1'b0; mem_ld = 1'b0;
  endtask

  task automatic do_reset(input logic [1:0] lv);
    rst = 1'b1; level = lv;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; level = 2'b00; pattern = '0; s_led_eq_pat = 1'b0;
    idle();
`ifdef SIMON_HISCORE_EN
    hi_clr = 1'b1;
`endif
    tick();
`ifdef SIMON_HISCORE_EN
    hi_clr = 1'b0;
`endif
    do_reset(2'b00);

    // Easy level and post-reset flags
    pattern = 4'b0001;
    chk("easy_0001_legal", S_LEGAL, 1);
    chk("reset_seq_len", S_SEQ, 1);
    chk("reset_i_lt_last", S_ILT, 0);
    chk("reset_arr_full", S_FULL, 0);
    tick();
    pattern = 4'b1111; chk("easy_1111_legal", S_LEGAL, 0); tick();
    pattern = 4'b0011; chk("easy_0011_legal", S_LEGAL, 0); tick();

    // Medium, hard, and level changes outside reset
    do_reset(2'b01);
    pattern = 4'b0011; chk("med_0011_legal", S_LEGAL, 1); tick();
    pattern = 4'b0111; chk("med_0111_legal", S_LEGAL, 0); tick();
    do_reset(2'b10);
    pattern = 4'b1111; chk("hard_1111_legal", S_LEGAL, 1); tick();
    pattern = 4'b0000; chk("hard_0000_legal", S_LEGAL, 0); tick();
    level = 2'b00;
    pattern = 4'b1111; chk("level_ignored_legal", S_LEGAL, 1); tick();
    do_reset(2'b11);
    pattern = 4'b0110; chk("hard11_0110_legal", S_LEGAL, 1); tick();

    // Load two entries and play them back with wrap
    do_reset(2'b00);
    pattern = 4'b0001; mem_ld = 1'b1; last_inc = 1'b1; tick();
    pattern = 4'b0010; mem_ld = 1'b1; last_inc = 1'b0; tick();
    idle(); i_clr = 1'b1; tick();
    idle();
    chk("load_seq_len", S_SEQ, 2);
    chk("play0_leds", S_LEDS, 4'b0001);
    chk("play0_i_lt_last", S_ILT, 1);
    i_inc = 1'b1; tick();
    chk("play1_leds", S_LEDS, 4'b0010);
    chk("play1_i_lt_last", S_ILT, 0);
    tick();
    chk("wrap_leds", S_LEDS, 4'b0001);
    tick();
    chk("wrap2_leds", S_LEDS, 4'b0010);
    idle();

    // Repeat check at i=1
    pattern = 4'b0010; chk("repeat_match", S_CORR, 1); tick();
    pattern = 4'b0100; chk("repeat_miss", S_CORR, 0);
    s_led_eq_pat = 1'b1; chk("leds_follow_pattern", S_LEDS, 4'b0100); tick();
    s_led_eq_pat = 1'b0;
    i_clr = 1'b1; i_inc = 1'b1; tick();
    idle();
    pattern = 4'b0001;
    chk("clr_wins_leds", S_LEDS, 4'b0001);
    chk("clr_wins_correct", S_CORR, 1);
    tick();

    // Fill to the end and saturate
    do_reset(2'b00);
    last_inc = 1'b1;
    for (int k = 0; k < int'(DEPTH) - 2; k++) tick();
    chk("near_full_arr_full", S_FULL, 0);
    chk("near_full_seq_len", S_SEQ, DEPTH - 1);
    tick();
    chk("full_arr_full", S_FULL, 1);
    chk("full_seq_len", S_SEQ, DEPTH);
    tick();
    chk("sat_arr_full", S_FULL, 1);
    chk("sat_seq_len", S_SEQ, DEPTH);
    idle(); i_inc = 1'b1; tick(); tick();
    chk("mid_i_lt_last", S_ILT, 1);
    rst = 1'b1; i_inc = 1'b1; last_inc = 1'b1; mem_ld = 1'b1; pattern = 4'b1000;
    tick();
    rst = 1'b0; idle();
    chk("rst_dom_seq_len", S_SEQ, 1);
    chk("rst_dom_i_lt_last", S_ILT, 0);
    chk("rst_dom_arr_full", S_FULL, 0);
    chk("rst_dom_leds", S_LEDS, 4'b0001);
    tick();

`ifdef SIMON_HISCORE_EN
    // High score survives reset and is cleared only by hi_clr
    hi_clr = 1'b1; tick(); hi_clr = 1'b0;
    do_reset(2'b00);
    chk("hi_init_score", S_HIS, 0);
    last_inc = 1'b1; tick(); tick(); idle();
    chk("hi_reach3_score", S_HIS, 3);
    chk("hi_reach3_new", S_HIN, 1);
    do_reset(2'b00);
    last_inc = 1'b1; tick(); idle();
    chk("hi_reach2_score", S_HIS, 3);
    chk("hi_reach2_new", S_HIN, 0);
    last_inc = 1'b1; tick(); tick(); idle();
    chk("hi_reach4_score", S_HIS, 4);
    chk("hi_reach4_new", S_HIN, 1);
    hi_clr = 1'b1; last_inc = 1'b1; tick(); hi_clr = 1'b0; idle();
    chk("hi_clr_score", S_HIS, 0);
    chk("hi_clr_new", S_HIN, 0);
    tick();
`endif

    tick();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
